// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Holds the FSM encoding and the parameter defaults.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int BURST_MAX_DEF  = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the FIFO write-port arbiter.
// master drives requests and full flag; slave is the arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  localparam int ID_WIDTH = id_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            ack;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         data_in;
  logic [ID_WIDTH-1:0]           owner_id;
  logic                          busy;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, ack, wr_en, data_in,
    input  owner_id, busy
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, ack, wr_en, data_in,
    output owner_id, busy
  );

endinterface

// File: rtl/fifo_rr_picker.sv
// Round-robin picker: first set req bit strictly after last_owner.
// Purely combinational, wraps modulo NUM_REQ.
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int ID_WIDTH = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_owner,
  output logic                valid,
  output logic [ID_WIDTH-1:0] index
);

  int                  s;
  logic [ID_WIDTH-1:0] idx;

  // Walk farthest-to-nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    s     = 0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      s = int'(last_owner) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      idx = ID_WIDTH'(s);
      if (req[idx]) begin
        valid = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for a single FIFO write port.
// One idle bubble separates consecutive grants.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input logic         wr_clk,
  input logic         rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_WIDTH = id_w(NUM_REQ);
  localparam int BW       = $clog2(BURST_MAX) + 1;

  localparam logic [ID_WIDTH-1:0] LAST_RST =
    ID_WIDTH'(NUM_REQ - 1);
  localparam logic [BW-1:0] BURST_END =
    BW'(BURST_MAX);

  arb_state_e          state_q, state_d;
  logic [ID_WIDTH-1:0] owner_q, owner_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_WIDTH-1:0] id_q;
  logic                busy_q;

  logic                pick_valid;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                owner_req;
  logic                wr_en;

  fifo_rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .req        (bus.req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  assign owner_req = bus.req[owner_q];
  assign wr_en     = (state_q == GRANT) & owner_req
                   & ~bus.fifo_full;

  assign bus.wr_en    = wr_en;
  assign bus.ack      = gnt_q & {NUM_REQ{wr_en}};
  assign bus.gnt      = gnt_q;
  assign bus.owner_id = id_q;
  assign bus.busy     = busy_q;
  assign bus.data_in  = (state_q == GRANT)
    ? bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH]
    : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    gnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          owner_d = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wr_en) begin
          beat_d = beat_q + 1'b1;
          if (beat_d == BURST_END) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      gnt_q   <= gnt_d;
      id_q    <= (state_d == GRANT) ? owner_d : '0;
      busy_q  <= (state_d == GRANT);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random
// traffic against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BM = 4;
  localparam int VW = 2*N + 1 + DW + 2 + 1;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: owner index (-1 = nobody), beats in burst, last owner.
  int m_owner;
  int m_beats;
  int m_last;

  logic [VW-1:0] obs_vec, exp_vec;
  logic          obs_wr;
  logic [N-1:0]  obs_gnt, obs_ack;
  logic [DW-1:0] obs_data;
  logic          obs_busy;

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = N - 1;
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic f,
                       input logic rn = 1'b1);
    logic [N-1:0]  eg;
    logic [DW-1:0] ed;
    logic [1:0]    eid;
    logic          ew;
    @(negedge wr_clk);
    rst_n         = rn;
    bus.req       = r;
    bus.fifo_full = f;
    for (int i = 0; i < N; i++)
      bus.req_data[i*DW +: DW] = DW'($urandom);
    #1;
    obs_wr   = bus.wr_en;
    obs_gnt  = bus.gnt;
    obs_ack  = bus.ack;
    obs_data = bus.data_in;
    obs_busy = bus.busy;
    obs_vec  = {bus.gnt, bus.ack, bus.wr_en, bus.data_in,
                bus.owner_id, bus.busy};
    if (!rn) model_reset();
    eg = '0; ed = '0; eid = '0; ew = 1'b0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eid = 2'(m_owner);
      ed  = bus.req_data[m_owner*DW +: DW];
      ew  = r[m_owner] && !f;
    end
    exp_vec = {eg, ew ? eg : {N{1'b0}}, ew, ed, eid,
               (m_owner >= 0)};
    if (rn) begin
      if (m_owner < 0) begin
        for (int j = 1; j <= N; j++) begin
          if (m_owner < 0 && r[(m_last + j) % N]) begin
            m_owner = (m_last + j) % N;
            m_beats = 0;
          end
        end
      end else if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (ew) begin
        m_beats++;
        if (m_beats == BM) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = '1;
    bus.fifo_full = 1'b0;
    bus.req_data = '1;
    #3;
    total++;
    if ({bus.gnt, bus.ack, bus.wr_en, bus.data_in,
         bus.owner_id, bus.busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
        {bus.gnt, bus.ack, bus.wr_en, bus.data_in,
         bus.owner_id, bus.busy});
    end
    model_reset();
    cycle('1, 1'b0, 1'b0);
    total++;
    if (obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_cycle got=%h want=%h",
               obs_vec, exp_vec);
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0] want_ack;
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 25; c++) begin
      cycle(4'b1111, 1'b0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL all_req_model c=%0d got=%h want=%h",
                 c, obs_vec, exp_vec);
      end
      want_ack = '0;
      if (c % 5 != 0) want_ack[(c / 5) % 4] = 1'b1;
      total++;
      if (obs_ack !== want_ack) begin
        bad++;
        $display("FAIL all_req_order c=%0d ack=%b want=%b",
                 c, obs_ack, want_ack);
      end
    end
  endtask

  task automatic test_single();
    int writes = 0;
    int cur = 0;
    int bursts[$];
    int want[3] = '{4, 4, 2};
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      cycle((writes < 10) ? 4'b0100 : 4'b0000, 1'b0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_model c=%0d got=%h want=%h",
                 c, obs_vec, exp_vec);
      end
      if (obs_wr) begin
        writes++;
        cur++;
        total++;
        if (obs_data !== bus.req_data[2*DW +: DW]) begin
          bad++;
          $display("FAIL single_data c=%0d got=%h want=%h",
                   c, obs_data, bus.req_data[2*DW +: DW]);
        end
      end else if (cur > 0) begin
        bursts.push_back(cur);
        cur = 0;
      end
    end
    total++;
    if (bursts.size() != 3) begin
      bad++;
      $display("FAIL single_nbursts got=%0d want=3",
               bursts.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (bursts[i] != want[i]) begin
          bad++;
          $display("FAIL single_burst%0d got=%0d want=%0d",
                   i, bursts[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int writes = 0;
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      cycle(4'b0010, (c >= 3 && c <= 5));
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL stall_model c=%0d got=%h want=%h",
                 c, obs_vec, exp_vec);
      end
      if (c <= 7 && obs_wr) writes++;
      if (c >= 3 && c <= 5) begin
        total++;
        if (obs_wr !== 1'b0 || obs_gnt !== 4'b0010) begin
          bad++;
          $display("FAIL stall_hold c=%0d wr=%b gnt=%b want wr=0 gnt=0010",
                   c, obs_wr, obs_gnt);
        end
      end
      if (c == 8) begin
        total++;
        if (obs_gnt !== 4'b0000) begin
          bad++;
          $display("FAIL stall_bubble gnt=%b want=0000",
                   obs_gnt);
        end
      end
    end
    total++;
    if (writes != 4) begin
      bad++;
      $display("FAIL stall_writes got=%0d want=4", writes);
    end
  endtask

  task automatic test_drop();
    logic [N-1:0] rs[5] = '{4'b1000, 4'b1000, 4'b0101,
                            4'b0101, 4'b0101};
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cycle(rs[c], 1'b0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL drop_model c=%0d got=%h want=%h",
                 c, obs_vec, exp_vec);
      end
    end
    total++;
    if (obs_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL drop_wrap gnt=%b want=0001", obs_gnt);
    end
  endtask

  task automatic test_reset_mid();
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b0100, 1'b0);
    total++;
    if (obs_wr !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre wr=%b want=1", obs_wr);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt, bus.wr_en, bus.ack, bus.busy,
         bus.data_in} !== '0) begin
      bad++;
      $display("FAIL mid_reset gnt=%b wr=%b ack=%b busy=%b",
               bus.gnt, bus.wr_en, bus.ack, bus.busy);
    end
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0);
    total++;
    if (obs_wr !== 1'b0 || obs_vec !== exp_vec) begin
      bad++;
      $display("FAIL mid_first got=%h want=%h",
               obs_vec, exp_vec);
    end
    cycle(4'b0010, 1'b0);
    total++;
    if (obs_gnt !== 4'b0010 || obs_wr !== 1'b1) begin
      bad++;
      $display("FAIL mid_regrant gnt=%b wr=%b want 0010/1",
               obs_gnt, obs_wr);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r = '0;
    logic         rn;
    cycle('0, 1'b0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      rn = ($urandom_range(149) != 0);
      cycle(r, ($urandom_range(3) == 0), rn);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++;
        $display("FAIL random c=%0d req=%b got=%h want=%h",
                 c, r, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_single();
    test_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
